// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: hands 6x6 operand pairs to an external sequential multiplier,
// waits a fixed latency, then captures the product together with the operands
// into a valid/ready output register.
module mult_seq_ctrl #(
  parameter int unsigned LAT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_a,
  input  logic [5:0]  in_b,
  output logic        m_load,
  output logic [5:0]  m_a,
  output logic [5:0]  m_b,
  input  logic [11:0] m_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_product,
  output logic [5:0]  out_a,
  output logic [5:0]  out_b,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        m_load_q;
  logic [5:0]  m_a_q;
  logic [5:0]  m_b_q;
  logic        out_valid_q;
  logic [11:0] out_product_q;
  logic [5:0]  out_a_q;
  logic [5:0]  out_b_q;
  logic        capture;

  // DONE may capture when the output register is empty or being drained this edge
  always_comb begin
    capture = (state_q == DONE) && (!out_valid_q || out_ready);
  end

  // Sequencer: accept, load strobe, fixed wait, capture; output register handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      m_load_q      <= 1'b0;
      m_a_q         <= '0;
      m_b_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            m_a_q    <= in_a;
            m_b_q    <= in_b;
            m_load_q <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          m_load_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAT_M1) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (capture) begin
            out_product_q <= m_product;
            out_a_q       <= m_a_q;
            out_b_q       <= m_b_q;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // a capture on the same edge as a consume keeps valid high with new data
      if (capture) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Reset has priority over an accept, so in_ready is masked during reset
  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
  end

  assign busy        = (state_q != IDLE);
  assign m_load      = m_load_q;
  assign m_a         = m_a_q;
  assign m_b         = m_b_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed and randomized checks of mult_seq_ctrl attached to
// a behavioural sequential multiplier, with an in-order result scoreboard.
module tb_mult_seq_ctrl;

  localparam int unsigned LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_a = '0;
  logic [5:0]  in_b = '0;
  logic        m_load;
  logic [5:0]  m_a;
  logic [5:0]  m_b;
  logic [11:0] m_product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_product;
  logic [5:0]  out_a;
  logic [5:0]  out_b;
  logic        busy;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  logic        rand_ready = 1'b0;

  mult_seq_ctrl #(.LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .m_load     (m_load),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_product  (m_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .out_a      (out_a),
    .out_b      (out_b),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Sequential multiplier: product valid 6 edges after the load edge, garbage before
  logic [11:0] mprod;
  logic [3:0]  mcnt;
  always @(posedge clk) begin
    if (rst) begin
      mcnt  <= '0;
      mprod <= '0;
    end else if (m_load) begin
      mcnt  <= 4'd6;
      mprod <= 12'(m_a) * 12'(m_b);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 4'd1;
    end
  end
  assign m_product = (mcnt == 0) ? mprod : 12'h5A5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: accepted operand pairs awaiting delivery, oldest first
  logic [11:0] sb_q[$];
  logic        stall_prev = 1'b0;
  logic [11:0] held_prod  = '0;
  logic [5:0]  ea;
  logic [5:0]  eb;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (out_valid) begin
        chk("sb_pending", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          ea = sb_q[0][11:6];
          eb = sb_q[0][5:0];
          chk("sb_prod", out_product, 32'(ea) * 32'(eb));
          chk("sb_a", out_a, ea);
          chk("sb_b", out_b, eb);
        end
        if (stall_prev) chk("sb_stable", out_product, held_prod);
        if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held_prod  = out_product;
      if (in_valid && in_ready) sb_q.push_back({in_a, in_b});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer a pair until accepted; returns at the sample point after the accept edge
  task automatic offer(input logic [5:0] a, input logic [5:0] b);
    int unsigned g;
    g = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    chk("offer_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("valid_timeout", out_valid, 1);
  endtask

  initial begin
    int unsigned n;
    int unsigned nl;
    logic seen;

    // reset, with in_valid asserted to show no accept happens on the reset edge
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 6'd63;
    in_b = 6'd63;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_m_load", m_load, 0);
    chk("rst_m_ab", {m_a, m_b}, 0);
    chk("rst_out", {out_product, out_a, out_b}, 0);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // 63*63, latency and single load strobe
    out_ready = 1'b1;
    offer(6'd63, 6'd63);
    n = 0;
    nl = m_load;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      nl += m_load;
    end
    chk("lat_63", n, LAT + 2);
    chk("mload_cycles", nl, 1);
    chk("prod_63", out_product, 3969);
    chk("a_63", out_a, 63);
    chk("b_63", out_b, 63);
    tick();
    chk("consumed_63", out_valid, 0);

    // back-to-back 0*45 then 45*1
    offer(6'd0, 6'd45);
    in_a = 6'd45;
    in_b = 6'd1;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("issue_interval", n + 1, LAT + 3);
    chk("b2b_first_prod", out_product, 0);
    chk("b2b_first_valid", out_valid, 1);
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("b2b_second_lat", n, LAT + 2);
    chk("b2b_second_prod", out_product, 45);
    tick();

    // backpressure: 12*11 held while 7*9 waits in DONE
    out_ready = 1'b0;
    offer(6'd12, 6'd11);
    in_a = 6'd7;
    in_b = 6'd9;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_valid", out_valid, 1);
    chk("stall_prod", out_product, 132);
    chk("stall_ab", {out_a, out_b}, {6'd12, 6'd11});
    chk("stall_in_ready", in_ready, 0);
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    tick();
    chk("swap_valid", out_valid, 1);
    chk("swap_prod", out_product, 63);
    chk("swap_ab", {out_a, out_b}, {6'd7, 6'd9});
    chk("swap_busy", busy, 0);
    tick();
    chk("swap_drained", out_valid, 0);

    // reset during WAIT with cnt=3 aborts 5*5
    offer(6'd5, 6'd5);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    seen = out_valid;
    repeat (15) begin
      tick();
      seen |= out_valid;
    end
    chk("abort_no_valid", seen, 0);
    offer(6'd2, 6'd3);
    wait_valid(n);
    chk("after_abort_lat", n, LAT + 2);
    chk("after_abort_prod", out_product, 6);
    tick();

    // randomized traffic against the scoreboard
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        in_a = 6'($urandom);
        in_b = 6'($urandom);
        tick();
      end
      offer(6'($urandom), 6'($urandom));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || out_valid || busy) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", sb_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 6, cycles spent in WAIT after the multiplier load edge before capture; legal range 6..15.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  operand pair accepted when in_valid & in_ready at a rising edge.
REQ-006 SHALL have ports in_a, in_b  input  6 each  unsigned operands.
REQ-007 SHALL have port m_load  output  1  load strobe to the 6x6 sequential multiplier.
REQ-008 SHALL have ports m_a, m_b  output  6 each  operands driven to the multiplier.
REQ-009 SHALL have port m_product  input  12  product returned by the multiplier.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result when out_valid & out_ready at a rising edge.
REQ-012 SHALL have ports out_product  output  12, out_a, out_b  output  6 each  captured result and echoed operands.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT, DONE; 4-bit counter cnt.
REQ-015 IDLE: in_ready=1; on in_valid, latch in_a/in_b into m_a/m_b, go LOAD.
REQ-016 In all other states, in_ready SHALL be 0; in_a/in_b ignored.
REQ-017 LOAD: m_load=1 for exactly this one cycle; cnt<=0; next state WAIT.
REQ-018 WAIT: m_load=0; cnt increments each cycle; at cnt==LAT-1 go DONE.
REQ-019 m_a/m_b SHALL hold the latched operands unchanged from accept until the next accept.
REQ-020 DONE: if out_valid==0 or out_ready==1, capture m_product->out_product, m_a->out_a, m_b->out_b, set out_valid, go IDLE; else stay DONE (backpressure stall, no capture).
REQ-021 out_valid SHALL clear on out_valid & out_ready unless a capture occurs the same edge, in which case out_valid stays 1 with the new data.
REQ-022 out_product/out_a/out_b SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Latency: accept edge E0 -> m_load high during cycle after E0 -> out_valid high after edge E0+LAT+2 (8 cycles at LAT=6) with no backpressure.
REQ-024 Issue interval without backpressure SHALL be LAT+3 cycles (in_ready returns high in the cycle after capture).
REQ-025 m_product SHALL be sampled only in DONE; no arithmetic performed in this block; widths pass unmodified.

Reset
REQ-026 On rst=1 at a rising edge: state=IDLE, cnt=0, m_load=0, m_a=m_b=0, out_valid=0, out_product=0, out_a=out_b=0.
REQ-027 During reset cycle in_ready SHALL be treated as 0 (no accept on the reset edge); in_ready=1 from the following cycle.
REQ-028 Reset mid-operation (LOAD/WAIT/DONE) SHALL abort the operation; pending and held results discarded; no out_valid pulse afterwards.
REQ-029 rst SHALL be shared with the attached multiplier so both restart together.

Verification
REQ-030 Bench: in_a=63, in_b=63, out_ready=1 -> out_valid after 8 cycles, out_product=3969 (0xF81), out_a=63, out_b=63; m_load high exactly 1 cycle.
REQ-031 Bench: in_a=0, in_b=45 then in_a=45, in_b=1 back-to-back -> results 0 then 45; second accept exactly 9 cycles after first.
REQ-032 Bench: first op 12*11, out_ready=0; second op 7*9 offered -> first result 132 held stable, FSM stalls in DONE with in_ready=0; raise out_ready -> 132 consumed, 63 captured same edge, out_valid stays 1.
REQ-033 Bench: rst pulsed during WAIT (cnt=3) of 5*5 -> out_valid never asserts for it; next op 2*3 returns 6 with normal latency.
REQ-034 Bench: random 1000 operand pairs with random out_ready/in_valid gaps against the team's sequential multiplier -> every out_product equals out_a*out_b, results in order, none dropped or duplicated.
